collect_2x1_rr_seq: RTL

// - Converging counterpart of the 1x2 distribute switch: merges two input streams into one output.
// - Each input port has its own small FIFO. One registered output stage drains the FIFOs.
// - i_cmd selects what is drained: low port only, high port only, or both via round-robin merge.
// - Sits at reduction/collection nodes of the NoC, where two branches rejoin toward a single consumer.

---
 rtl/collect_2x1_rr_seq.sv | 93 +++++++++
 1 files changed

// File: rtl/collect_2x1_rr_seq.sv
// collect_2x1_rr_seq: merges two FIFO-buffered input streams into one registered output (COLLECT_REDUCE_EN turns cmd 11 into reduce-add)
module collect_2x1_rr_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDR_WIDTH    = 2
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                i_valid,
  input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
  output logic [1:0]                o_ready,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data_bus,
  output logic [1:0]                o_src,
  input  logic                      i_ready,
  input  logic                      i_en,
  input  logic [COMMAND_WIDTH-1:0]  i_cmd
);
  localparam logic [ADDR_WIDTH:0]   full_cnt = FIFO_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   cnt_one  = 1;
  localparam logic [ADDR_WIDTH-1:0] ptr_one  = 1;
  logic [1:0] push, pop, not_empty, sel;
  logic [DATA_WIDTH-1:0] head [2];
  logic [DATA_WIDTH-1:0] load_data;
  logic cmd_lo, cmd_hi, cmd_mg, load;
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    // Storage is not reset; only entries counted by count are ever read out
    always_ff @(posedge clk)
      if (push[g]) mem[wr_ptr] <= i_data_bus[g*DATA_WIDTH +: DATA_WIDTH];
    // Pointers wrap naturally at FIFO_DEPTH; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + ptr_one;
        if (pop[g]) rd_ptr <= rd_ptr + ptr_one;
        count <= (push[g] & !pop[g]) ? count + cnt_one :
                 (!push[g] & pop[g]) ? count - cnt_one : count;
      end
    assign o_ready[g]   = count != full_cnt;
    assign not_empty[g] = count != '0;
    assign push[g]      = i_valid[g] & o_ready[g];
    assign head[g]      = mem[rd_ptr];
  end
  assign cmd_lo = i_cmd == COMMAND_WIDTH'(1);
  assign cmd_hi = i_cmd == COMMAND_WIDTH'(2);
  assign cmd_mg = i_cmd == COMMAND_WIDTH'(3);
`ifdef COLLECT_REDUCE_EN
  // Reduce mode consumes one word from each port together, so both must be waiting
  always_comb begin
    sel = cmd_lo ? {1'b0, not_empty[0]} :
          cmd_hi ? {not_empty[1], 1'b0} :
          (cmd_mg & (&not_empty)) ? 2'b11 : 2'b00;
  end
`else
  logic rr_ptr;
  // Round-robin only arbitrates when both ports have data; otherwise the busy port wins
  always_comb begin
    sel = cmd_lo ? {1'b0, not_empty[0]} :
          cmd_hi ? {not_empty[1], 1'b0} :
          !cmd_mg ? 2'b00 :
          (&not_empty) ? (rr_ptr ? 2'b10 : 2'b01) : not_empty;
  end
  // Priority passes to the port that was not served by the last merge grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= 1'b0;
    else if (load & cmd_mg) rr_ptr <= sel[0];
`endif
  assign load      = i_en & (|sel) & (!o_valid | i_ready);
  assign pop       = {2{load}} & sel;
  assign load_data = sel[1] ? (sel[0] ? head[0] + head[1] : head[1]) : head[0];
  // Output register: refill whenever empty or being drained, clear once drained with nothing to refill
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_src      <= 2'b00;
    end else if (load) begin
      o_valid    <= 1'b1;
      o_data_bus <= load_data;
      o_src      <= sel;
    end else if (o_valid & i_ready) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_src      <= 2'b00;
    end
endmodule
